// File: rtl/pushbutton_debounce_if.sv
// Button-side bundle for pushbutton_debounce: raw key pins in, debounced levels out.
// press_pulse exists only when PB_DEBOUNCE_PULSE_EN is defined.
interface pushbutton_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] key_n;
    logic [WIDTH-1:0] pb_out;
`ifdef PB_DEBOUNCE_PULSE_EN
    logic [WIDTH-1:0] press_pulse;

    modport master (output key_n, input pb_out, input press_pulse);
    modport slave  (input key_n, output pb_out, output press_pulse);
`else
    modport master (output key_n, input pb_out);
    modport slave  (input key_n, output pb_out);
`endif
endinterface

// File: rtl/pushbutton_debounce.sv
// Per-channel pushbutton debouncer: 2-flop synchronizer, then a stable-level qualification counter.
// Optional one-cycle press strobe enabled by defining PB_DEBOUNCE_PULSE_EN.
module pushbutton_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pushbutton_debounce_if.slave  bus
);
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_pbOut;
    logic [CW-1:0]    r_cnt [WIDTH];

    logic [WIDTH-1:0] w_sampled;
    logic [WIDTH-1:0] w_differs;
    logic [WIDTH-1:0] w_load;

    // Synchronizer resets to 1 so an idle (released) key looks stable straight out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= bus.key_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sampled = ~r_sync2;
    assign w_differs = w_sampled ^ r_pbOut;

    always_comb begin
        w_load = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_load[i] = w_differs[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    // Any sample agreeing with the current output restarts qualification from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pbOut <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_differs[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_load[i]) begin
                    r_cnt[i]   <= '0;
                    r_pbOut[i] <= w_sampled[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.pb_out = r_pbOut;

`ifdef PB_DEBOUNCE_PULSE_EN
    logic [WIDTH-1:0] r_pressPulse;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pressPulse <= '0;
        end else begin
            r_pressPulse <= w_load & w_sampled;
        end
    end

    assign bus.press_pulse = r_pressPulse;
`endif
endmodule

// File: tb/tb_pushbutton_debounce.sv
// Self-checking bench for pushbutton_debounce: segment table, reset corner cases,
// then random key activity compared against a history-based reference model.
module tb_pushbutton_debounce;
    localparam int WIDTH = 4;
    localparam int DC    = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    pushbutton_debounce_if #(.WIDTH(WIDTH)) bus ();

    pushbutton_debounce #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    // One segment holds keyN for a number of edges; pb_out switches from pbStart to pbEnd on edge changeAt.
    typedef struct {
        logic [WIDTH-1:0] keyN;
        int               edges;
        logic [WIDTH-1:0] pbStart;
        logic [WIDTH-1:0] pbEnd;
        int               changeAt;
        string            name;
    } seg_t;

    seg_t segs [9];

    logic [WIDTH-1:0] hist [$];
    int               lastChg [WIDTH];
    logic [WIDTH-1:0] mPb;
    logic [WIDTH-1:0] mPulse;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] keyN);
        bus.key_n = keyN;
        @(posedge clk);
        #1;
    endtask

    // Level seen by the counter logic on a given edge: the key pin captured two edges earlier.
    function automatic logic sampledAt(input int edgeIdx, input int ch);
        logic [WIDTH-1:0] k;
        if (edgeIdx <= 2) return 1'b0;
        k = hist[edgeIdx-3];
        return ~k[ch];
    endfunction

    // A channel flips once DC consecutive edges since its last change have all disagreed with it.
    task automatic modelStep();
        int e;
        int run;
        e      = hist.size();
        mPulse = '0;
        for (int ch = 0; ch < WIDTH; ch++) begin
            run = 0;
            for (int j = e; j > lastChg[ch] && j >= 1 && run < DC; j--) begin
                if (sampledAt(j, ch) != mPb[ch]) run++;
                else break;
            end
            if (run == DC) begin
                mPb[ch]     = ~mPb[ch];
                lastChg[ch] = e;
                if (mPb[ch]) mPulse[ch] = 1'b1;
            end
        end
    endtask

    task automatic resetDut();
        bus.key_n = '1;
        reset_n   = 1'b0;
        #1;
        checkOutput("reset pb_out", bus.pb_out, '0);
`ifdef PB_DEBOUNCE_PULSE_EN
        checkOutput("reset press_pulse", bus.press_pulse, '0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] key;
        logic [WIDTH-1:0] expPb;
        logic [WIDTH-1:0] expPulse;

        segs[0] = '{4'b1110, 10, 4'b0000, 4'b0001, 6, "clean press ch0"};
        segs[1] = '{4'b1100,  3, 4'b0001, 4'b0001, 0, "bounce low ch1"};
        segs[2] = '{4'b1110,  1, 4'b0001, 4'b0001, 0, "bounce high ch1"};
        segs[3] = '{4'b1100,  8, 4'b0001, 4'b0011, 6, "bounce hold ch1"};
        segs[4] = '{4'b1000,  6, 4'b0011, 4'b0111, 6, "press ch2"};
        segs[5] = '{4'b1100,  6, 4'b0111, 4'b0011, 6, "release ch2"};
        segs[6] = '{4'b1111,  6, 4'b0011, 4'b0000, 6, "release ch0 ch1"};
        segs[7] = '{4'b0000,  8, 4'b0000, 4'b1111, 6, "press all"};
        segs[8] = '{4'b1111,  6, 4'b1111, 4'b0000, 6, "release all"};

        resetDut();

        for (int s = 0; s < 9; s++) begin
            for (int k = 1; k <= segs[s].edges; k++) begin
                applyStimulus(segs[s].keyN);
                expPb = (segs[s].changeAt != 0 && k >= segs[s].changeAt) ? segs[s].pbEnd : segs[s].pbStart;
                checkOutput($sformatf("%s pb_out edge %0d", segs[s].name, k), bus.pb_out, expPb);
`ifdef PB_DEBOUNCE_PULSE_EN
                expPulse = (k == segs[s].changeAt) ? (segs[s].pbEnd & ~segs[s].pbStart) : '0;
                checkOutput($sformatf("%s press_pulse edge %0d", segs[s].name, k), bus.press_pulse, expPulse);
`endif
            end
        end

        // Reset in the middle of qualifying a held ch3 press must throw the partial count away.
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(4'b0111);
            checkOutput($sformatf("midcount pb_out edge %0d", k), bus.pb_out, 4'b0000);
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midcount in reset", bus.pb_out, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midcount held in reset", bus.pb_out, 4'b0000);
        reset_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(4'b0111);
            checkOutput($sformatf("after reset pb_out edge %0d", k), bus.pb_out,
                        (k >= 6) ? 4'b1000 : 4'b0000);
`ifdef PB_DEBOUNCE_PULSE_EN
            checkOutput($sformatf("after reset press_pulse edge %0d", k), bus.press_pulse,
                        (k == 6) ? 4'b1000 : 4'b0000);
`endif
        end

        // Asserting reset clears a high output without waiting for a clock edge.
        reset_n = 1'b0;
        #1;
        checkOutput("async clear pb_out", bus.pb_out, 4'b0000);

        resetDut();
        hist.delete();
        for (int ch = 0; ch < WIDTH; ch++) lastChg[ch] = 0;
        mPb    = '0;
        mPulse = '0;
        key    = '1;
        for (int n = 0; n < 3000; n++) begin
            for (int ch = 0; ch < WIDTH; ch++) begin
                if ($urandom_range(0, 9) == 0) key[ch] = ~key[ch];
            end
            applyStimulus(key);
            hist.push_back(key);
            modelStep();
            checkOutput($sformatf("random pb_out step %0d", n), bus.pb_out, mPb);
`ifdef PB_DEBOUNCE_PULSE_EN
            checkOutput($sformatf("random press_pulse step %0d", n), bus.press_pulse, mPulse);
`endif
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
